// File: rtl/register_file_16x32.sv
// register_file_16x32
// Sixteen 32-bit general-purpose registers with two combinational read ports
// (A, B) and one clocked write port (C). The write address is decoded to a
// one-hot load vector gated by load_enable; a synchronous active-high reset
// clears every register and wins over a simultaneous write.
module register_file_16x32 (
  output logic [31:0] port_a,
  output logic [31:0] port_b,
  input  logic [3:0]  a_select,
  input  logic [3:0]  b_select,
  input  logic [31:0] port_c,
  input  logic [3:0]  decoder_control,
  input  logic        load_enable,
  input  logic        clk,
  input  logic        reset
);

  localparam int unsigned NUM_REGS = 16;

  logic [31:0]         regs [NUM_REGS];
  logic [NUM_REGS-1:0] load;

  // 4-to-16 destination decoder, gated by the write enable into a one-hot load.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    load = '0;
    if (load_enable) begin
      load[decoder_control] = 1'b1;
    end
  end

  // Register storage: clear on reset, otherwise load the decoded register.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this array is a bank of flops, not a RAM macro, so it can be
      // cleared in one cycle; a true memory would need a sweep instead.
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: state is updated with <= so every read of regs in this edge
        // sees the pre-edge value, which models real flip-flops.
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load[i]) begin
          regs[i] <= port_c;
        end
      end
    end
  end

  // Two independent 16:1 read multiplexers; no bypass from port C.
  always_comb begin
    port_a = regs[a_select];
    port_b = regs[b_select];
  end

endmodule

// File: tb/tb_register_file_16x32.sv
// tb_register_file_16x32
// Directed test of the 16x32 register file: reset, fill, write disable,
// overwrite timing, dual read, synchronous reset, reset priority and the
// R0/R15 boundary registers. Inputs change 1 ns after a rising edge and
// outputs are sampled between edges.
module tb_register_file_16x32;

  logic [31:0] port_a;
  logic [31:0] port_b;
  logic [3:0]  a_select;
  logic [3:0]  b_select;
  logic [31:0] port_c;
  logic [3:0]  decoder_control;
  logic        load_enable;
  logic        clk;
  logic        reset;

  int checks;
  int errors;

  register_file_16x32 dut (
    .port_a          (port_a),
    .port_b          (port_b),
    .a_select        (a_select),
    .b_select        (b_select),
    .port_c          (port_c),
    .decoder_control (decoder_control),
    .load_enable     (load_enable),
    .clk             (clk),
    .reset           (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and let combinational reads settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a_select = 4'(k);
      b_select = 4'(15 - k);
      #1;
      checks++;
      if (port_a !== 32'h0 || port_b !== 32'h0) begin
        errors++;
        $display("FAIL reset_clear r%0d: port_a=%h port_b=%h expected 00000000", k, port_a, port_b);
      end
    end
  endtask

  task automatic test_fill();
    load_enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      decoder_control = 4'(k);
      port_c          = 32'(k);
      tick();
    end
    load_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_select = 4'(2 * i);
      b_select = 4'(2 * i + 1);
      #1;
      checks++;
      if (port_a !== 32'(2 * i) || port_b !== 32'(2 * i + 1)) begin
        errors++;
        $display("FAIL fill_sweep step %0d: port_a=%h port_b=%h expected %h %h",
                 i, port_a, port_b, 32'(2 * i), 32'(2 * i + 1));
      end
    end
  endtask

  task automatic test_write_disable();
    load_enable     = 1'b0;
    decoder_control = 4'd10;
    port_c          = 32'd99;
    a_select        = 4'd10;
    repeat (3) tick();
    checks++;
    if (port_a !== 32'd10) begin
      errors++;
      $display("FAIL write_disable: port_a=%h expected %h", port_a, 32'd10);
    end
  endtask

  task automatic test_overwrite();
    a_select        = 4'd10;
    load_enable     = 1'b1;
    decoder_control = 4'd10;
    port_c          = 32'd50;
    #1;
    checks++;
    if (port_a !== 32'd10) begin
      errors++;
      $display("FAIL overwrite_before_edge: port_a=%h expected %h", port_a, 32'd10);
    end
    tick();
    load_enable = 1'b0;
    checks++;
    if (port_a !== 32'd50) begin
      errors++;
      $display("FAIL overwrite_after_edge: port_a=%h expected %h", port_a, 32'd50);
    end
    for (int k = 0; k < 16; k++) begin
      if (k != 10) begin
        b_select = 4'(k);
        #1;
        checks++;
        if (port_b !== 32'(k)) begin
          errors++;
          $display("FAIL overwrite_others r%0d: port_b=%h expected %h", k, port_b, 32'(k));
        end
      end
    end
  endtask

  task automatic test_dual_read();
    a_select = 4'd7;
    b_select = 4'd7;
    #1;
    checks++;
    if (port_a !== 32'd7 || port_b !== 32'd7) begin
      errors++;
      $display("FAIL dual_read: port_a=%h port_b=%h expected 00000007", port_a, port_b);
    end
  endtask

  task automatic test_sync_reset();
    a_select = 4'd5;
    b_select = 4'd10;
    reset    = 1'b1;
    #2;
    checks++;
    if (port_a !== 32'd5 || port_b !== 32'd50) begin
      errors++;
      $display("FAIL reset_held_before_edge: port_a=%h port_b=%h expected %h %h",
               port_a, port_b, 32'd5, 32'd50);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a_select = 4'(k);
      b_select = 4'(k);
      #1;
      checks++;
      if (port_a !== 32'h0 || port_b !== 32'h0) begin
        errors++;
        $display("FAIL sync_reset_clear r%0d: port_a=%h port_b=%h expected 00000000", k, port_a, port_b);
      end
    end
  endtask

  task automatic test_reset_priority();
    a_select        = 4'd3;
    load_enable     = 1'b1;
    decoder_control = 4'd3;
    port_c          = 32'h0000_0055;
    tick();
    checks++;
    if (port_a !== 32'h0000_0055) begin
      errors++;
      $display("FAIL priority_setup: port_a=%h expected 00000055", port_a);
    end
    reset  = 1'b1;
    port_c = 32'hFFFF_FFFF;
    tick();
    reset       = 1'b0;
    load_enable = 1'b0;
    #1;
    checks++;
    if (port_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_priority: port_a=%h expected 00000000", port_a);
    end
    load_enable = 1'b1;
    port_c      = 32'h0000_00A5;
    tick();
    load_enable = 1'b0;
    checks++;
    if (port_a !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL write_after_reset: port_a=%h expected 000000a5", port_a);
    end
  endtask

  task automatic test_boundary();
    load_enable     = 1'b1;
    decoder_control = 4'd0;
    port_c          = 32'hDEAD_BEEF;
    tick();
    decoder_control = 4'd15;
    port_c          = 32'h1234_5678;
    tick();
    load_enable = 1'b0;
    a_select = 4'd0;
    b_select = 4'd15;
    #1;
    checks++;
    if (port_a !== 32'hDEAD_BEEF || port_b !== 32'h1234_5678) begin
      errors++;
      $display("FAIL boundary_a0_b15: port_a=%h port_b=%h expected deadbeef 12345678", port_a, port_b);
    end
    a_select = 4'd15;
    b_select = 4'd0;
    #1;
    checks++;
    if (port_a !== 32'h1234_5678 || port_b !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL boundary_a15_b0: port_a=%h port_b=%h expected 12345678 deadbeef", port_a, port_b);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b0;
    load_enable     = 1'b0;
    decoder_control = 4'd0;
    port_c          = 32'd0;
    a_select        = 4'd0;
    b_select        = 4'd0;
    #1;

    test_reset();
    test_fill();
    test_write_disable();
    test_overwrite();
    test_dual_read();
    test_sync_reset();
    test_reset_priority();
    test_boundary();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
